// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module : uart_tx_arbiter_if
// Brief  : Requester byte streams and the UART transmitter handshake for the
//          shared-transmitter arbiter, bundled as one port.
// Rev    : 1.0  initial release
// =============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_done;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 err_timeout;

    // Master is the environment (byte sources plus transmitter); slave is the arbiter.
    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_data, tx_send, grant_id, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_data, tx_send, grant_id, busy, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin, message-atomic sharing of one byte UART transmitter.
// Rev    : 1.0  initial release
// =============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire              clk,
    input  wire              reset,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_LAST_IDX = 3'(NUM_REQ - 1);
    localparam logic [7:0] c_ACK_LAST = 8'(ACK_TIMEOUT - 1);

    state_t               state_q;
    logic [7:0]           tx_data_q;
    logic                 tx_send_q;
    logic [2:0]           grant_q;
    logic                 lock_q;
    logic                 last_q;
    logic [2:0]           rr_q;
    logic [7:0]           cnt_q;
    logic                 err_q;

    logic                 w_sel_valid;
    logic [2:0]           w_sel_idx;
    logic [7:0]           w_sel_byte;
    logic                 w_sel_last;
    logic [NUM_REQ-1:0]   w_ready;
    logic [2:0]           w_rr_next;

    // A message owner keeps the grant; otherwise search upward from rr, wrapping.
    always_comb begin : p_select
        logic [3:0] pos;
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        pos         = '0;
        if (state_q == ST_IDLE && bus.tx_done) begin
            if (lock_q) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == 3'(i) && bus.req_valid[i]) begin
                        w_sel_valid = 1'b1;
                        w_sel_idx   = 3'(i);
                    end
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    pos = {1'b0, rr_q} + 4'(k);
                    if (pos >= 4'(NUM_REQ)) begin
                        pos = pos - 4'(NUM_REQ);
                    end
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (!w_sel_valid && pos[2:0] == 3'(i) && bus.req_valid[i]) begin
                            w_sel_valid = 1'b1;
                            w_sel_idx   = 3'(i);
                        end
                    end
                end
            end
        end
    end

    always_comb begin : p_mux
        w_sel_byte = '0;
        w_sel_last = 1'b0;
        w_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == 3'(i)) begin
                w_sel_byte = bus.req_data[8*i +: 8];
                w_sel_last = bus.req_last[i];
            end
            w_ready[i] = w_sel_valid && (w_sel_idx == 3'(i));
        end
    end

    assign w_rr_next = (grant_q == c_LAST_IDX) ? 3'd0 : grant_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            grant_q   <= 3'd0;
            lock_q    <= 1'b0;
            last_q    <= 1'b0;
            rr_q      <= 3'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            tx_send_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        tx_data_q <= w_sel_byte;
                        grant_q   <= w_sel_idx;
                        lock_q    <= ~w_sel_last;
                        last_q    <= w_sel_last;
                        tx_send_q <= 1'b1;
                        state_q   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    cnt_q   <= 8'd0;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!bus.tx_done) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == c_ACK_LAST) begin
                        // Transmitter never took the byte: drop it and free the channel.
                        err_q   <= 1'b1;
                        lock_q  <= 1'b0;
                        rr_q    <= w_rr_next;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state_q <= ST_IDLE;
                        if (last_q) begin
                            lock_q <= 1'b0;
                            rr_q   <= w_rr_next;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_send     = tx_send_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = lock_q | (state_q != ST_IDLE);
    assign bus.err_timeout = err_q;

endmodule
`default_nettype wire
